// File: rtl/arb_req_pkg.sv
// Shared types and defaults for the arbiter request front end.
package arb_req_pkg;

    // Per-channel slot state.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        REQ     = 2'd1,
        SERVE   = 2'd2,
        RELEASE = 2'd3
    } chan_state_e;

    localparam int CNT_W_DEF       = 3;
    localparam int HOLD_CYCLES_DEF = 4;
    localparam int WDOG_LIMIT_DEF  = 64;
    localparam int WDOG_W          = 16;
    // Hold counter width covers HOLD_CYCLES up to 255.
    localparam int HOLD_W          = 8;

endpackage

// File: rtl/arb_req_frontend_chan.sv
// One request channel: pending counter, slot FSM, hold counter and the
// optional starvation watchdog (compiled in with ARB_REQ_WATCHDOG_EN).
module arb_req_chan
    import arb_req_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
`ifdef ARB_REQ_WATCHDOG_EN
    ,
    parameter int WDOG_LIMIT  = WDOG_LIMIT_DEF
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_in,
    input  logic             gnt,
    input  logic             ovf_clr,
    output logic             req,
    output logic             done,
    output logic [CNT_W-1:0] pend,
    output logic             ovf,
    output logic             starve,
    output chan_state_e      state
);

    localparam logic [CNT_W-1:0]  PEND_MAX  = '1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    chan_state_e       state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  pend_q, pend_d;
    logic              retire;
    logic              ovf_set;
    logic              ovf_q, req_q, done_q;

    // A slot retires on the last granted SERVE cycle.
    assign retire = (state_q == SERVE) && gnt && (hold_q == '0);

    // Pending count: a pulse and a retire together cancel; a pulse at
    // saturation is dropped and flagged.
    always_comb begin
        pend_d  = pend_q;
        ovf_set = 1'b0;
        if (req_in && !retire) begin
            if (pend_q == PEND_MAX) ovf_set = 1'b1;
            else                    pend_d  = pend_q + CNT_W'(1);
        end else if (!req_in && retire) begin
            pend_d = pend_q - CNT_W'(1);
        end
    end

    // Slot FSM next state and hold counter; gnt outside REQ/SERVE is ignored.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            EMPTY: begin
                if (pend_d != '0) state_d = REQ;
            end
            REQ: begin
                if (gnt) begin
                    state_d = SERVE;
                    hold_d  = HOLD_LOAD;
                end
            end
            SERVE: begin
                if (!gnt)                 state_d = REQ;
                else if (hold_q == '0)    state_d = RELEASE;
                else                      hold_d  = hold_q - HOLD_W'(1);
            end
            RELEASE: begin
                if (!gnt) state_d = (pend_d != '0) ? REQ : EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // FSM state and hold counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Pending count, sticky overflow (set beats clear) and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
            ovf_q  <= 1'b0;
            req_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (ovf_set)      ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
            req_q  <= (state_q == REQ) || (state_q == SERVE);
            done_q <= retire;
        end
    end

`ifdef ARB_REQ_WATCHDOG_EN
    logic [WDOG_W-1:0] wait_q;
    logic              starve_q;

    // Count cycles spent waiting in REQ; flag starvation once the limit is hit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_q   <= '0;
            starve_q <= 1'b0;
        end else begin
            if (state_q == REQ) begin
                if (wait_q != '1) wait_q <= wait_q + WDOG_W'(1);
            end else begin
                wait_q <= '0;
            end
            if ((state_q == REQ) && (wait_q == WDOG_W'(WDOG_LIMIT))) starve_q <= 1'b1;
            else if (ovf_clr)                                      starve_q <= 1'b0;
        end
    end

    assign starve = starve_q;
`else
    assign starve = 1'b0;
`endif

    assign req   = req_q;
    assign done  = done_q;
    assign pend  = pend_q;
    assign ovf   = ovf_q;
    assign state = state_q;

endmodule

// File: rtl/arb_req_frontend.sv
// Request-conditioning stage in front of the two-requester grant FSM.
// Optional starvation watchdog: define ARB_REQ_WATCHDOG_EN.
//
// req/gnt handshake: req_k is a level, high while channel k waits (REQ) or
// is being served (SERVE); gnt_k is sampled every cycle. HOLD_CYCLES
// consecutive granted SERVE cycles complete a slot (done_k pulses), after
// which req_k drops for at least one cycle and stays low until gnt_k is seen
// low, so the arbiter passes through IDLE before the next slot.
// state_0/state_1 expose each channel's FSM state for observation.
module arb_req_frontend
    import arb_req_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
`ifdef ARB_REQ_WATCHDOG_EN
    ,
    parameter int WDOG_LIMIT  = WDOG_LIMIT_DEF
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_in_0,
    input  logic             req_in_1,
    input  logic             gnt_0,
    input  logic             gnt_1,
    input  logic             ovf_clr,
    output logic             req_0,
    output logic             req_1,
    output logic             done_0,
    output logic             done_1,
    output logic [CNT_W-1:0] pend_0,
    output logic [CNT_W-1:0] pend_1,
    output logic             ovf_0,
    output logic             ovf_1,
    output logic             starve_0,
    output logic             starve_1,
    output chan_state_e      state_0,
    output chan_state_e      state_1
);

    arb_req_chan #(
        .CNT_W       (CNT_W),
        .HOLD_CYCLES (HOLD_CYCLES)
`ifdef ARB_REQ_WATCHDOG_EN
        ,
        .WDOG_LIMIT  (WDOG_LIMIT)
`endif
    ) u_chan_0 (
        .clock   (clock),
        .reset   (reset),
        .req_in  (req_in_0),
        .gnt     (gnt_0),
        .ovf_clr (ovf_clr),
        .req     (req_0),
        .done    (done_0),
        .pend    (pend_0),
        .ovf     (ovf_0),
        .starve  (starve_0),
        .state   (state_0)
    );

    arb_req_chan #(
        .CNT_W       (CNT_W),
        .HOLD_CYCLES (HOLD_CYCLES)
`ifdef ARB_REQ_WATCHDOG_EN
        ,
        .WDOG_LIMIT  (WDOG_LIMIT)
`endif
    ) u_chan_1 (
        .clock   (clock),
        .reset   (reset),
        .req_in  (req_in_1),
        .gnt     (gnt_1),
        .ovf_clr (ovf_clr),
        .req     (req_1),
        .done    (done_1),
        .pend    (pend_1),
        .ovf     (ovf_1),
        .starve  (starve_1),
        .state   (state_1)
    );

endmodule

// File: tb/tb_arb_req_frontend.sv
// Self-checking bench for arb_req_frontend: directed scenarios followed by a
// randomized run against a slot-schedule reference model.
module tb_arb_req_frontend;
    import arb_req_pkg::*;

    localparam int CNT_W = CNT_W_DEF;
    localparam int HOLD  = HOLD_CYCLES_DEF;
    localparam int PMAX  = (1 << CNT_W) - 1;
    localparam int WLIM  = WDOG_LIMIT_DEF;
`ifdef ARB_REQ_WATCHDOG_EN
    localparam int WD_ON = 1;
`else
    localparam int WD_ON = 0;
`endif

    logic             clock, reset;
    logic             req_in_0, req_in_1, gnt_0, gnt_1, ovf_clr;
    logic             req_0, req_1, done_0, done_1, ovf_0, ovf_1, starve_0, starve_1;
    logic [CNT_W-1:0] pend_0, pend_1;
    chan_state_e      state_0, state_1;

    int               n_checks = 0;
    int               n_pass   = 0;
    int               n_fail   = 0;
    bit               auto0, auto1;
    logic [CNT_W-1:0] exp_q[$];

    arb_req_frontend #(.CNT_W(CNT_W), .HOLD_CYCLES(HOLD)) dut (
        .clock    (clock),
        .reset    (reset),
        .req_in_0 (req_in_0),
        .req_in_1 (req_in_1),
        .gnt_0    (gnt_0),
        .gnt_1    (gnt_1),
        .ovf_clr  (ovf_clr),
        .req_0    (req_0),
        .req_1    (req_1),
        .done_0   (done_0),
        .done_1   (done_1),
        .pend_0   (pend_0),
        .pend_1   (pend_1),
        .ovf_0    (ovf_0),
        .ovf_1    (ovf_1),
        .starve_0 (starve_0),
        .starve_1 (starve_1),
        .state_0  (state_0),
        .state_1  (state_1)
    );

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Model arbiter: grant channel k in the cycle it sees req_k.
    task automatic step();
        if (auto0) gnt_0 = req_0;
        if (auto1) gnt_1 = req_1;
        tick();
    endtask

    task automatic pulse0();
        req_in_0 = 1'b1;
        step();
        req_in_0 = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        req_in_0 = 1'b0;
        req_in_1 = 1'b0;
        gnt_0    = 1'b0;
        gnt_1    = 1'b0;
        ovf_clr  = 1'b0;
        auto0    = 1'b0;
        auto1    = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic wait_done0(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (done_0) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic wait_req(input int ch, output int ok);
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            if ((ch == 0 && req_0) || (ch == 1 && req_1)) begin
                ok = 1;
                break;
            end
            step();
        end
    endtask

    initial begin
        int lat, ok, ndone, low_seen, seen_done;
        int m_pend[2], m_req_at[2], m_done_at[2];
        bit m_busy[2], m_ovf[2], e_req[2], e_done[2], ri[2];
        bit r_ret, r_evt, clr;

        // Reset values while reset is held
        reset = 1'b0;
        req_in_0 = 0; req_in_1 = 0; gnt_0 = 0; gnt_1 = 0; ovf_clr = 0;
        auto0 = 0; auto1 = 0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_req0",   32'(req_0), 0);
        check("rst_req1",   32'(req_1), 0);
        check("rst_done0",  32'(done_0), 0);
        check("rst_pend0",  32'(pend_0), 0);
        check("rst_pend1",  32'(pend_1), 0);
        check("rst_ovf0",   32'(ovf_0), 0);
        check("rst_starve1", 32'(starve_1), 0);
        check("rst_state0", 32'(state_0), 32'(EMPTY));
        reset = 1'b1;
        tick();

        // Single request on channel 0
        pulse0();
        check("single_pend1",  32'(pend_0), 1);
        check("single_state",  32'(state_0), 32'(REQ));
        check("single_req_lo", 32'(req_0), 0);
        step();
        check("single_req_hi", 32'(req_0), 1);
        step();
        step();
        gnt_0 = 1'b1;
        wait_done0(lat);
        check("single_lat",      32'(lat), 32'(HOLD + 1));
        check("single_pend0",    32'(pend_0), 0);
        step();
        check("single_req_drop", 32'(req_0), 0);
        check("single_done_once", 32'(done_0), 0);
        gnt_0 = 1'b0;
        step();
        check("single_empty",    32'(state_0), 32'(EMPTY));
        check("single_done_quiet", 32'(done_0), 0);

        // Back-to-back requests on channel 1
        auto1 = 1'b1;
        req_in_1 = 1'b1;
        repeat (3) step();
        req_in_1 = 1'b0;
        check("b2b_pend3", 32'(pend_1), 3);
        exp_q.push_back(CNT_W'(2));
        exp_q.push_back(CNT_W'(1));
        exp_q.push_back(CNT_W'(0));
        ndone = 0;
        low_seen = 0;
        for (int k = 0; k < 80 && ndone < 3; k++) begin
            step();
            if (!req_1) low_seen = 1;
            if (done_1) begin
                ndone++;
                if (ndone > 1) check("b2b_gap", 32'(low_seen), 1);
                low_seen = 0;
                check("b2b_pend", 32'(pend_1), 32'(exp_q.pop_front()));
            end
        end
        check("b2b_ndone", 32'(ndone), 3);
        repeat (4) step();
        check("b2b_idle_req", 32'(req_1), 0);
        check("b2b_idle_state", 32'(state_1), 32'(EMPTY));
        auto1 = 1'b0;
        gnt_1 = 1'b0;

        // Saturation and sticky overflow
        do_reset();
        repeat (9) pulse0();
        check("sat_pend", 32'(pend_0), 32'(PMAX));
        check("sat_ovf",  32'(ovf_0), 1);
        check("sat_ovf1", 32'(ovf_1), 0);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("sat_clr_ovf",  32'(ovf_0), 0);
        check("sat_clr_pend", 32'(pend_0), 32'(PMAX));
        req_in_0 = 1'b1;
        ovf_clr  = 1'b1;
        step();
        req_in_0 = 1'b0;
        ovf_clr  = 1'b0;
        check("sat_set_wins", 32'(ovf_0), 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("sat_clr2", 32'(ovf_0), 0);

        // Increment coincident with retire
        do_reset();
        pulse0();
        pulse0();
        check("sim_req_hi", 32'(req_0), 1);
        gnt_0 = 1'b1;
        repeat (HOLD) step();
        check("sim_pend_pre", 32'(pend_0), 2);
        check("sim_no_done",  32'(done_0), 0);
        req_in_0 = 1'b1;
        step();
        req_in_0 = 1'b0;
        check("sim_done", 32'(done_0), 1);
        check("sim_pend", 32'(pend_0), 2);
        check("sim_ovf",  32'(ovf_0), 0);

        // Preemption after two of the hold cycles
        gnt_0 = 1'b0;
        step();
        wait_req(0, ok);
        check("pre_req_wait", 32'(ok), 1);
        gnt_0 = 1'b1;
        seen_done = 0;
        repeat (3) begin
            step();
            if (done_0) seen_done = 1;
        end
        gnt_0 = 1'b0;
        step();
        if (done_0) seen_done = 1;
        check("pre_no_done", 32'(seen_done), 0);
        check("pre_pend",    32'(pend_0), 2);
        check("pre_state",   32'(state_0), 32'(REQ));
        gnt_0 = 1'b1;
        wait_done0(lat);
        check("pre_reload_lat", 32'(lat), 32'(HOLD + 1));
        check("pre_pend_after", 32'(pend_0), 1);

        // Asynchronous reset in the middle of a slot
        gnt_0 = 1'b0;
        step();
        wait_req(0, ok);
        check("rst_mid_req_wait", 32'(ok), 1);
        gnt_0 = 1'b1;
        step();
        step();
        check("rst_mid_serve", 32'(state_0), 32'(SERVE));
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_req",   32'(req_0), 0);
        check("rst_mid_pend",  32'(pend_0), 0);
        check("rst_mid_state", 32'(state_0), 32'(EMPTY));
        check("rst_mid_done",  32'(done_0), 0);
        tick();
        reset = 1'b1;
        seen_done = 0;
        repeat (HOLD + 2) begin
            step();
            if (done_0) seen_done = 1;
        end
        check("rst_mid_no_done", 32'(seen_done), 0);
        check("rst_mid_idle",    32'(state_0), 32'(EMPTY));
        gnt_0 = 1'b0;

        // Starvation watchdog on channel 1
        do_reset();
        req_in_1 = 1'b1;
        step();
        req_in_1 = 1'b0;
        wait_req(1, ok);
        check("wd_req_wait", 32'(ok), 1);
        repeat (WLIM - 1) step();
        check("wd_before", 32'(starve_1), 0);
        step();
        check("wd_at_limit", 32'(starve_1), 32'(WD_ON));
        check("wd_other",    32'(starve_0), 0);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("wd_clr", 32'(starve_1), 0);

        // Randomized traffic against the slot-schedule model
        do_reset();
        auto0 = 1'b1;
        auto1 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = 0; m_ovf[k] = 0; m_busy[k] = 0;
            m_req_at[k] = -100; m_done_at[k] = -100;
        end
        for (int c = 0; c < 400; c++) begin
            ri[0] = ($urandom_range(0, 99) < 35);
            ri[1] = ($urandom_range(0, 99) < 35);
            clr   = ($urandom_range(0, 99) < 4);
            req_in_0 = ri[0];
            req_in_1 = ri[1];
            ovf_clr  = clr;
            for (int k = 0; k < 2; k++) begin
                r_ret = m_busy[k] && (m_done_at[k] == c + 1);
                r_evt = 1'b0;
                if (ri[k] && !r_ret) begin
                    if (m_pend[k] == PMAX) r_evt = 1'b1;
                    else                   m_pend[k]++;
                end else if (!ri[k] && r_ret) begin
                    m_pend[k]--;
                end
                if (r_evt)    m_ovf[k] = 1'b1;
                else if (clr) m_ovf[k] = 1'b0;
                // A slot enters REQ the cycle after it can start, reaches done
                // HOLD+2 cycles later, and the next slot may enter REQ two
                // cycles after done.
                if (!m_busy[k] || (c == m_done_at[k] + 1)) begin
                    if (m_pend[k] > 0) begin
                        m_busy[k]    = 1'b1;
                        m_req_at[k]  = c + 1;
                        m_done_at[k] = c + 1 + HOLD + 2;
                    end else begin
                        m_busy[k] = 1'b0;
                    end
                end
                e_done[k] = r_ret;
                e_req[k]  = m_busy[k] && (c + 1 > m_req_at[k]) && (c + 1 <= m_done_at[k]);
            end
            step();
            check("rnd_pend0", 32'(pend_0), 32'(m_pend[0]));
            check("rnd_pend1", 32'(pend_1), 32'(m_pend[1]));
            check("rnd_ovf0",  32'(ovf_0),  32'(m_ovf[0]));
            check("rnd_ovf1",  32'(ovf_1),  32'(m_ovf[1]));
            check("rnd_req0",  32'(req_0),  32'(e_req[0]));
            check("rnd_req1",  32'(req_1),  32'(e_req[1]));
            check("rnd_done0", 32'(done_0), 32'(e_done[0]));
            check("rnd_done1", 32'(done_1), 32'(e_done[1]));
        end
        req_in_0 = 1'b0;
        req_in_1 = 1'b0;
        ovf_clr  = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
